// File: rtl/ps2_key_decoder_if.sv
// Key-event bus between the PS/2 byte receiver side and the key decoder.
// The slave modport is the decoder: it consumes the byte stream and drives
// the key event outputs. The master modport is whoever feeds bytes in and
// watches the events.
interface ps2_key_decoder_if;
  logic [7:0] data;
  logic       data_ready;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_repeat;
  logic       key_held;
  logic [7:0] press_count;
  logic [7:0] ascii;

  modport slave (
    input  data, data_ready,
    output key_valid, key_code, key_ext, key_break, key_repeat, key_held,
           press_count, ascii
  );

  modport master (
    output data, data_ready,
    input  key_valid, key_code, key_ext, key_break, key_repeat, key_held,
           press_count, ascii
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Scan Code Set 2 key decoder.
// Assembles E0 (extended), F0 (break) and E1 (pause) byte sequences into
// single key events, tracks typematic repeat of the held key and counts
// distinct presses. A prefix left dangling for TIMEOUT clocks is dropped.
// Optional ASCII translation is enabled with `define PS2_KEY_DECODER_ASCII_EN;
// without it ascii is constant zero and no shift state exists.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT   = 1000000,
  parameter int unsigned PAUSE_LEN = 7
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_decoder_if.slave kbd
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PW = (PAUSE_LEN > 0) ? $clog2(PAUSE_LEN + 1) : 1;

  localparam logic [7:0] B_EXT    = 8'hE0;
  localparam logic [7:0] B_BRK    = 8'hF0;
  localparam logic [7:0] B_PAUSE  = 8'hE1;
  localparam logic [7:0] C_PAUSE  = 8'h77;
  localparam logic [7:0] C_LSHIFT = 8'h12;
  localparam logic [7:0] C_RSHIFT = 8'h59;

  typedef enum logic [2:0] {
    S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   pause_cnt_q, pause_cnt_d;

  logic            ev_fire, ev_ext, ev_break;
  logic [7:0]      ev_code;
  logic            is_mod, same_key, ev_repeat;

  logic            key_valid_q, key_ext_q, key_break_q, key_repeat_q, key_held_q;
  logic [7:0]      key_code_q, press_count_q;
  logic [7:0]      last_code_q;
  logic            last_ext_q;

  // Sequence FSM: consume one byte per strobe, expire dangling prefixes.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    pause_cnt_d = pause_cnt_q;
    ev_fire     = 1'b0;
    ev_code     = kbd.data;
    ev_ext      = 1'b0;
    ev_break    = 1'b0;
    if (kbd.data_ready) begin
      // A byte always wins over a simultaneous timer expiry.
      timer_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (kbd.data == B_EXT)        state_d = S_EXT;
          else if (kbd.data == B_BRK)   state_d = S_BRK;
          else if (kbd.data == B_PAUSE) begin
            state_d     = S_PAUSE;
            pause_cnt_d = PW'(PAUSE_LEN);
          end else ev_fire = 1'b1;
        end
        S_EXT: begin
          if (kbd.data == B_BRK)      state_d = S_EXT_BRK;
          else if (kbd.data != B_EXT) begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          ev_fire  = 1'b1;
          ev_break = 1'b1;
          state_d  = S_IDLE;
        end
        S_EXT_BRK: begin
          ev_fire  = 1'b1;
          ev_ext   = 1'b1;
          ev_break = 1'b1;
          state_d  = S_IDLE;
        end
        S_PAUSE: begin
          if (pause_cnt_q <= PW'(1)) begin
            // Whole Pause sequence swallowed: report it as one extended press.
            ev_fire     = 1'b1;
            ev_ext      = 1'b1;
            ev_code     = C_PAUSE;
            pause_cnt_d = '0;
            state_d     = S_IDLE;
          end else begin
            pause_cnt_d = pause_cnt_q - PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (timer_q == TW'(TIMEOUT - 1)) begin
        state_d     = S_IDLE;
        timer_d     = '0;
        pause_cnt_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // Sequence FSM state, prefix timer and pause byte counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      pause_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      state_q     <= state_d;
      timer_q     <= timer_d;
      pause_cnt_q <= pause_cnt_d;
    end
  end

  // Event classification against the currently held key.
  always_comb begin
    is_mod    = !ev_ext && ((ev_code == C_LSHIFT) || (ev_code == C_RSHIFT));
    same_key  = ({ev_ext, ev_code} == {last_ext_q, last_code_q});
    ev_repeat = !ev_break && !is_mod && key_held_q && same_key;
  end

  // Registered key event outputs, held-key tracking and press counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_break_q   <= 1'b0;
      key_repeat_q  <= 1'b0;
      key_held_q    <= 1'b0;
      press_count_q <= '0;
      last_code_q   <= '0;
      last_ext_q    <= 1'b0;
    end else begin
      key_valid_q <= ev_fire;
      if (ev_fire) begin
        key_code_q   <= ev_code;
        key_ext_q    <= ev_ext;
        key_break_q  <= ev_break;
        key_repeat_q <= ev_repeat;
        if (!ev_break && !is_mod) begin
          if (!ev_repeat) press_count_q <= press_count_q + 8'd1;
          last_code_q <= ev_code;
          last_ext_q  <= ev_ext;
          key_held_q  <= 1'b1;
        end else if (ev_break && same_key) begin
          key_held_q <= 1'b0;
        end
      end
    end
  end

`ifdef PS2_KEY_DECODER_ASCII_EN
  logic       shift_l_q, shift_r_q;
  logic [7:0] ascii_q;

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                               input logic       shifted);
    logic [7:0] lower;
    lower         = 8'h00;
    scan_to_ascii = 8'h00;
    case (code)
      8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
      8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
      8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
      default: lower = 8'h00;
    endcase
    if (lower != 8'h00) begin
      scan_to_ascii = shifted ? (lower - 8'h20) : lower;
    end else begin
      case (code)
        8'h45: scan_to_ascii = shifted ? 8'h29 : 8'h30;
        8'h16: scan_to_ascii = shifted ? 8'h21 : 8'h31;
        8'h1E: scan_to_ascii = shifted ? 8'h40 : 8'h32;
        8'h26: scan_to_ascii = shifted ? 8'h23 : 8'h33;
        8'h25: scan_to_ascii = shifted ? 8'h24 : 8'h34;
        8'h2E: scan_to_ascii = shifted ? 8'h25 : 8'h35;
        8'h36: scan_to_ascii = shifted ? 8'h5E : 8'h36;
        8'h3D: scan_to_ascii = shifted ? 8'h26 : 8'h37;
        8'h3E: scan_to_ascii = shifted ? 8'h2A : 8'h38;
        8'h46: scan_to_ascii = shifted ? 8'h28 : 8'h39;
        8'h29: scan_to_ascii = 8'h20;
        8'h5A: scan_to_ascii = 8'h0A;
        8'h66: scan_to_ascii = 8'h08;
        default: scan_to_ascii = 8'h00;
      endcase
    end
  endfunction

  // Shift tracking and ASCII latched alongside each event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
      ascii_q   <= '0;
    end else if (ev_fire) begin
      if (!ev_ext && ev_code == C_LSHIFT) shift_l_q <= !ev_break;
      if (!ev_ext && ev_code == C_RSHIFT) shift_r_q <= !ev_break;
      ascii_q <= (ev_break || ev_ext) ? 8'h00
                                      : scan_to_ascii(ev_code, shift_l_q | shift_r_q);
    end
  end

  assign kbd.ascii = ascii_q;
`else
  assign kbd.ascii = 8'h00;
`endif

  assign kbd.key_valid   = key_valid_q;
  assign kbd.key_code    = key_code_q;
  assign kbd.key_ext     = key_ext_q;
  assign kbd.key_break   = key_break_q;
  assign kbd.key_repeat  = key_repeat_q;
  assign kbd.key_held    = key_held_q;
  assign kbd.press_count = press_count_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: a directed vector table from
// reset, a reset in the middle of a Pause sequence, then random byte streams
// checked against a queue-based sequence model.
module tb_ps2_key_decoder;

  localparam int TO = 8;
  localparam int PL = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ps2_key_decoder_if kbd ();

  ps2_key_decoder #(.TIMEOUT(TO), .PAUSE_LEN(PL)) dut (
    .clk (clk),
    .rst (rst_n),
    .kbd (kbd)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] pend[$];
  logic       m_held, m_last_ext, m_shl, m_shr;
  logic [7:0] m_last_code, m_cnt;
  logic       e_ext, e_brk, e_rep;
  logic [7:0] e_code, e_asc;

  function automatic logic [7:0] model_ascii(input logic [7:0] code, input logic shifted);
`ifdef PS2_KEY_DECODER_ASCII_EN
    logic [7:0] letters [26];
    logic [7:0] digits  [10];
    logic [7:0] sdigits [10];
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    sdigits = '{")", "!", "@", "#", "$", "%", "^", "&", "*", "("};
    for (int i = 0; i < 26; i++)
      if (letters[i] == code) return 8'((shifted ? "A" : "a") + i);
    for (int i = 0; i < 10; i++)
      if (digits[i] == code) return shifted ? sdigits[i] : 8'("0" + i);
    if (code == 8'h29) return " ";
    if (code == 8'h5A) return 8'h0A;
    if (code == 8'h66) return 8'h08;
    return 8'h00;
`else
    return (code == 8'hFF && shifted) ? 8'h00 : 8'h00;
`endif
  endfunction

  function automatic void model_reset();
    pend.delete();
    m_held = 0; m_last_ext = 0; m_shl = 0; m_shr = 0; m_last_code = 0; m_cnt = 0;
    e_ext = 0; e_brk = 0; e_rep = 0; e_code = 0; e_asc = 0;
  endfunction

  function automatic void model_event(input logic [7:0] code, input logic ext, input logic brk);
    logic is_mod;
    logic match;
    is_mod = !ext && (code == 8'h12 || code == 8'h59);
    match  = (code == m_last_code) && (ext == m_last_ext);
    e_code = code; e_ext = ext; e_brk = brk;
    if (!brk) begin
      e_rep = m_held && match;
      e_asc = ext ? 8'h00 : model_ascii(code, m_shl || m_shr);
      if (is_mod) begin
        if (code == 8'h12) m_shl = 1; else m_shr = 1;
      end else begin
        if (!e_rep) m_cnt = m_cnt + 8'd1;
        m_last_code = code; m_last_ext = ext; m_held = 1;
      end
    end else begin
      e_rep = 0;
      e_asc = 8'h00;
      if (match) m_held = 0;
      if (!ext && code == 8'h12) m_shl = 0;
      if (!ext && code == 8'h59) m_shr = 0;
    end
  endfunction

  // Feed one byte arriving after 'idle' strobe-free clocks; returns whether
  // it completes a key event.
  function automatic logic model_byte(input logic [7:0] b, input int idle);
    logic f0_before;
    if (idle >= TO && pend.size() > 0) pend.delete();
    pend.push_back(b);
    if (pend[0] == 8'hE1) begin
      if (pend.size() == PL + 1) begin
        pend.delete();
        model_event(8'h77, 1'b1, 1'b0);
        return 1'b1;
      end
      return 1'b0;
    end
    f0_before = 0;
    for (int i = 0; i < pend.size() - 1; i++)
      if (pend[i] == 8'hF0) f0_before = 1;
    if (!f0_before && (b == 8'hE0 || b == 8'hF0)) return 1'b0;
    model_event(b, pend[0] == 8'hE0, f0_before);
    pend.delete();
    return 1'b1;
  endfunction

  task automatic check_outputs(input string tag, input logic exp_valid);
    check({tag, "_valid"},  kbd.key_valid,   exp_valid);
    check({tag, "_code"},   kbd.key_code,    e_code);
    check({tag, "_ext"},    kbd.key_ext,     e_ext);
    check({tag, "_break"},  kbd.key_break,   e_brk);
    check({tag, "_repeat"}, kbd.key_repeat,  e_rep);
    check({tag, "_held"},   kbd.key_held,    m_held);
    check({tag, "_count"},  kbd.press_count, m_cnt);
    check({tag, "_ascii"},  kbd.ascii,       e_asc);
  endtask

  // Called at a negedge with data_ready low; returns at the negedge after
  // the strobe, where the event (if any) is visible.
  task automatic send(input logic [7:0] b, input int idle, input string tag);
    logic ev;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      check({tag, "_idle_valid"}, kbd.key_valid, 1'b0);
    end
    ev = model_byte(b, idle);
    kbd.data       = b;
    kbd.data_ready = 1'b1;
    @(negedge clk);
    kbd.data_ready = 1'b0;
    check_outputs(tag, ev);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] b;
    int         idle;
    logic       v;
    logic [7:0] code;
    logic       ext, brk, rep, held;
    logic [7:0] cnt;
    logic [7:0] asc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] b, input int idle, input logic v, input logic [7:0] code,
                     input logic ext, input logic brk, input logic rep, input logic held,
                     input logic [7:0] cnt, input logic [7:0] asc);
    vec_t r;
    r.b = b; r.idle = idle; r.v = v; r.code = code; r.ext = ext; r.brk = brk;
    r.rep = rep; r.held = held; r.cnt = cnt; r.asc = asc;
    tbl.push_back(r);
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] pool [16];
    int r;
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h1C, 8'h32, 8'h1A, 8'h45,
             8'h16, 8'h46, 8'h29, 8'h5A, 8'h66, 8'h75, 8'h77};
    r = $urandom_range(0, 19);
    if (r < 16) return pool[r];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    vec_t v;
    int idle;
    int r;
    kbd.data       = 8'h00;
    kbd.data_ready = 1'b0;
    rst_n          = 1'b0;
    model_reset();

    //      byte  idle v  code  e  b  r  h  cnt    ascii(enabled)
    add(8'h1C, 2, 1, 8'h1C, 0, 0, 0, 1, 8'd1,  8'h61);
    add(8'hF0, 0, 0, 8'h1C, 0, 0, 0, 1, 8'd1,  8'h61);
    add(8'h1C, 0, 1, 8'h1C, 0, 1, 0, 0, 8'd1,  8'h00);
    add(8'h12, 1, 1, 8'h12, 0, 0, 0, 0, 8'd1,  8'h00);
    add(8'h1C, 0, 1, 8'h1C, 0, 0, 0, 1, 8'd2,  8'h41);
    add(8'hF0, 1, 0, 8'h1C, 0, 0, 0, 1, 8'd2,  8'h41);
    add(8'h1C, 0, 1, 8'h1C, 0, 1, 0, 0, 8'd2,  8'h00);
    add(8'hF0, 0, 0, 8'h1C, 0, 1, 0, 0, 8'd2,  8'h00);
    add(8'h12, 0, 1, 8'h12, 0, 1, 0, 0, 8'd2,  8'h00);
    add(8'h1C, 1, 1, 8'h1C, 0, 0, 0, 1, 8'd3,  8'h61);
    add(8'hE0, 1, 0, 8'h1C, 0, 0, 0, 1, 8'd3,  8'h61);
    add(8'h75, 0, 1, 8'h75, 1, 0, 0, 1, 8'd4,  8'h00);
    add(8'hE0, 1, 0, 8'h75, 1, 0, 0, 1, 8'd4,  8'h00);
    add(8'hF0, 0, 0, 8'h75, 1, 0, 0, 1, 8'd4,  8'h00);
    add(8'h75, 2, 1, 8'h75, 1, 1, 0, 0, 8'd4,  8'h00);
    add(8'h1C, 1, 1, 8'h1C, 0, 0, 0, 1, 8'd5,  8'h61);
    add(8'h1C, 0, 1, 8'h1C, 0, 0, 1, 1, 8'd5,  8'h61);
    add(8'h1C, 3, 1, 8'h1C, 0, 0, 1, 1, 8'd5,  8'h61);
    add(8'hF0, 1, 0, 8'h1C, 0, 0, 1, 1, 8'd5,  8'h61);
    add(8'h1C, 0, 1, 8'h1C, 0, 1, 0, 0, 8'd5,  8'h00);
    // E0 left dangling for exactly TIMEOUT clocks is discarded.
    add(8'hE0, 1, 0, 8'h1C, 0, 1, 0, 0, 8'd5,  8'h00);
    add(8'h1C, TO, 1, 8'h1C, 0, 0, 0, 1, 8'd6, 8'h61);
    // Byte arriving on the expiry cycle still completes the sequence.
    add(8'hE0, 1, 0, 8'h1C, 0, 0, 0, 1, 8'd6,  8'h61);
    add(8'h6B, TO-1, 1, 8'h6B, 1, 0, 0, 1, 8'd7, 8'h00);
    // Pause: E1 followed by seven swallowed bytes, one press event only.
    add(8'hE1, 1, 0, 8'h6B, 1, 0, 0, 1, 8'd7,  8'h00);
    add(8'h14, 0, 0, 8'h6B, 1, 0, 0, 1, 8'd7,  8'h00);
    add(8'h77, 0, 0, 8'h6B, 1, 0, 0, 1, 8'd7,  8'h00);
    add(8'hE1, 1, 0, 8'h6B, 1, 0, 0, 1, 8'd7,  8'h00);
    add(8'hF0, 0, 0, 8'h6B, 1, 0, 0, 1, 8'd7,  8'h00);
    add(8'h14, 0, 0, 8'h6B, 1, 0, 0, 1, 8'd7,  8'h00);
    add(8'hF0, 1, 0, 8'h6B, 1, 0, 0, 1, 8'd7,  8'h00);
    add(8'h77, 0, 1, 8'h77, 1, 0, 0, 1, 8'd8,  8'h00);
    // Right shift with a digit, then space after shift release.
    add(8'h59, 1, 1, 8'h59, 0, 0, 0, 1, 8'd8,  8'h00);
    add(8'h16, 0, 1, 8'h16, 0, 0, 0, 1, 8'd9,  8'h21);
    add(8'hF0, 1, 0, 8'h16, 0, 0, 0, 1, 8'd9,  8'h21);
    add(8'h59, 0, 1, 8'h59, 0, 1, 0, 1, 8'd9,  8'h00);
    add(8'h29, 2, 1, 8'h29, 0, 0, 0, 1, 8'd10, 8'h20);

    repeat (3) @(negedge clk);
    check_outputs("reset", 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      send(v.b, v.idle, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_valid", i),  kbd.key_valid,   v.v);
      check($sformatf("tbl%0d_code", i),   kbd.key_code,    v.code);
      check($sformatf("tbl%0d_ext", i),    kbd.key_ext,     v.ext);
      check($sformatf("tbl%0d_break", i),  kbd.key_break,   v.brk);
      check($sformatf("tbl%0d_repeat", i), kbd.key_repeat,  v.rep);
      check($sformatf("tbl%0d_held", i),   kbd.key_held,    v.held);
      check($sformatf("tbl%0d_count", i),  kbd.press_count, v.cnt);
`ifdef PS2_KEY_DECODER_ASCII_EN
      check($sformatf("tbl%0d_ascii", i),  kbd.ascii,       v.asc);
`else
      check($sformatf("tbl%0d_ascii", i),  kbd.ascii,       8'h00);
`endif
    end

    // Reset asserted in the middle of a Pause sequence.
    send(8'hE1, 1, "prst_e1");
    send(8'h14, 0, "prst_14");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h1C, 1, "postrst");
    check("postrst_count_one", kbd.press_count, 8'd1);
    check("postrst_ext_zero",  kbd.key_ext,     1'b0);
    check("postrst_press",     kbd.key_valid,   1'b1);

    // Randomized byte streams with mixed gaps, including timeout boundaries.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       idle = r % 3;
      else if (r == 6) idle = TO - 1;
      else if (r == 7) idle = TO;
      else if (r == 8) idle = TO + 1;
      else             idle = 0;
      send(pick_byte(), idle, $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    check("final_valid_low", kbd.key_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
